// File: rtl/processor_core.sv
// processor_core: single-cycle 32-bit core with 2K-word IM/DM loaded through side ports while loading=1.
// Define PROCESSOR_R0_ZERO_EN to hardwire R0 to zero; by default R0 is an ordinary register.
module processor_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loading,
  input  logic        im_cen_load,
  input  logic        im_wen_load,
  input  logic        im_oen_load,
  input  logic [10:0] im_addr_load,
  input  logic [31:0] im_datain_load,
  input  logic        dm_cen_load,
  input  logic        dm_wen_load,
  input  logic        dm_oen_load,
  input  logic [10:0] dm_addr_load,
  input  logic [31:0] dm_datain_load,
  output logic [31:0] pc,
  output logic [31:0] ir
);
  localparam logic [6:0] OP_NOP  = 7'b0000000;
  localparam logic [6:0] OP_MOVA = 7'b1000000;
  localparam logic [6:0] OP_MOVB = 7'b0001100;
  localparam logic [6:0] OP_ADD  = 7'b0000010;
  localparam logic [6:0] OP_SUB  = 7'b0000101;
  localparam logic [6:0] OP_AND  = 7'b0001000;
  localparam logic [6:0] OP_OR   = 7'b0001001;
  localparam logic [6:0] OP_XOR  = 7'b0001010;
  localparam logic [6:0] OP_NOT  = 7'b0001011;
  localparam logic [6:0] OP_ADI  = 7'b0100010;
  localparam logic [6:0] OP_SBI  = 7'b0100101;
  localparam logic [6:0] OP_ANI  = 7'b0101000;
  localparam logic [6:0] OP_ORI  = 7'b0101001;
  localparam logic [6:0] OP_XRI  = 7'b0101010;
  localparam logic [6:0] OP_LSR  = 7'b0001101;
  localparam logic [6:0] OP_LSL  = 7'b0001110;
  localparam logic [6:0] OP_SLT  = 7'b1100101;
  localparam logic [6:0] OP_LD   = 7'b0010000;
  localparam logic [6:0] OP_ST   = 7'b0100000;
  localparam logic [6:0] OP_BZ   = 7'b1100000;
  localparam logic [6:0] OP_BNZ  = 7'b1001000;
  localparam logic [6:0] OP_JMP  = 7'b1101000;
  localparam logic [6:0] OP_JML  = 7'b0110000;
  localparam logic [6:0] OP_JMR  = 7'b1110000;

  logic [31:0] im [2048];
  logic [31:0] dm [2048];
  logic [31:0] rf [32];
  logic [6:0]  opcode;
  logic [4:0]  dr, sa, sb, sh;
  logic [31:0] ra, rb, se_imm, ze_imm, wdata, pc_next, pc_inc, pc_rel;
  logic        we, st, rf_we;
  logic        unused_oen;

  assign unused_oen = im_oen_load ^ dm_oen_load;
  assign ir     = im[pc[10:0]];
  assign opcode = ir[31:25];
  assign dr     = ir[24:20];
  assign sa     = ir[19:15];
  assign sb     = ir[14:10];
  assign sh     = ir[4:0];
  assign se_imm = {{17{ir[14]}}, ir[14:0]};
  assign ze_imm = {17'b0, ir[14:0]};
  assign pc_inc = pc + 32'd1;
  assign pc_rel = pc + se_imm;

`ifdef PROCESSOR_R0_ZERO_EN
  assign ra    = (sa == 5'd0) ? '0 : rf[sa];
  assign rb    = (sb == 5'd0) ? '0 : rf[sb];
  assign rf_we = we && !loading && (dr != 5'd0);
`else
  assign ra    = rf[sa];
  assign rb    = rf[sb];
  assign rf_we = we && !loading;
`endif

  // Unknown opcodes fall through to the NOP defaults.
  always_comb begin
    wdata   = '0;
    we      = 1'b0;
    st      = 1'b0;
    pc_next = pc_inc;
    case (opcode)
      OP_NOP:  ;
      OP_MOVA: begin wdata = ra;                               we = 1'b1; end
      OP_MOVB: begin wdata = rb;                               we = 1'b1; end
      OP_ADD:  begin wdata = ra + rb;                          we = 1'b1; end
      OP_SUB:  begin wdata = ra - rb;                          we = 1'b1; end
      OP_AND:  begin wdata = ra & rb;                          we = 1'b1; end
      OP_OR:   begin wdata = ra | rb;                          we = 1'b1; end
      OP_XOR:  begin wdata = ra ^ rb;                          we = 1'b1; end
      OP_NOT:  begin wdata = ~ra;                              we = 1'b1; end
      OP_ADI:  begin wdata = ra + se_imm;                      we = 1'b1; end
      OP_SBI:  begin wdata = ra - se_imm;                      we = 1'b1; end
      OP_ANI:  begin wdata = ra & ze_imm;                      we = 1'b1; end
      OP_ORI:  begin wdata = ra | ze_imm;                      we = 1'b1; end
      OP_XRI:  begin wdata = ra ^ ze_imm;                      we = 1'b1; end
      OP_LSR:  begin wdata = ra >> sh;                         we = 1'b1; end
      OP_LSL:  begin wdata = ra << sh;                         we = 1'b1; end
      OP_SLT:  begin wdata = {31'b0, $signed(ra) < $signed(rb)}; we = 1'b1; end
      OP_LD:   begin wdata = dm[ra[10:0]];                     we = 1'b1; end
      OP_ST:   st = 1'b1;
      OP_BZ:   pc_next = (ra == '0) ? pc_rel : pc_inc;
      OP_BNZ:  pc_next = (ra != '0) ? pc_rel : pc_inc;
      OP_JMP:  pc_next = pc_rel;
      OP_JML:  begin wdata = pc_inc; we = 1'b1; pc_next = pc_rel; end
      OP_JMR:  pc_next = ra;
      default: ;
    endcase
  end

  always_ff @(posedge clk)
    if (loading && !im_cen_load && !im_wen_load)
      im[im_addr_load] <= im_datain_load;

  always_ff @(posedge clk)
    if (loading) begin
      if (!dm_cen_load && !dm_wen_load)
        dm[dm_addr_load] <= dm_datain_load;
    end else if (st)
      dm[ra[10:0]] <= rb;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    else if (rf_we)
      rf[dr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      pc <= '0;
    else if (!loading)
      pc <= pc_next;
endmodule

// File: tb/tb_processor_core.sv
// tb_processor_core: directed programs with hand-computed results for processor_core.
module tb_processor_core;
  localparam logic [6:0] OP_MOVA = 7'b1000000, OP_MOVB = 7'b0001100, OP_ADD = 7'b0000010;
  localparam logic [6:0] OP_SUB = 7'b0000101, OP_AND = 7'b0001000, OP_OR = 7'b0001001;
  localparam logic [6:0] OP_XOR = 7'b0001010, OP_NOT = 7'b0001011, OP_ADI = 7'b0100010;
  localparam logic [6:0] OP_SBI = 7'b0100101, OP_ANI = 7'b0101000, OP_ORI = 7'b0101001;
  localparam logic [6:0] OP_XRI = 7'b0101010, OP_LSR = 7'b0001101, OP_LSL = 7'b0001110;
  localparam logic [6:0] OP_SLT = 7'b1100101, OP_LD = 7'b0010000, OP_ST = 7'b0100000;
  localparam logic [6:0] OP_BZ = 7'b1100000, OP_BNZ = 7'b1001000, OP_JMP = 7'b1101000;
  localparam logic [6:0] OP_JML = 7'b0110000, OP_JMR = 7'b1110000;

  logic        clk = 0, rst_n = 0, loading = 1;
  logic        im_cen_load = 1, im_wen_load = 1, im_oen_load = 1;
  logic        dm_cen_load = 1, dm_wen_load = 1, dm_oen_load = 1;
  logic [10:0] im_addr_load = '0, dm_addr_load = '0;
  logic [31:0] im_datain_load = '0, dm_datain_load = '0;
  logic [31:0] pc, ir;
  int checks = 0, failures = 0;

  processor_core dut (
    .clk(clk), .rst_n(rst_n), .loading(loading),
    .im_cen_load(im_cen_load), .im_wen_load(im_wen_load), .im_oen_load(im_oen_load),
    .im_addr_load(im_addr_load), .im_datain_load(im_datain_load),
    .dm_cen_load(dm_cen_load), .dm_wen_load(dm_wen_load), .dm_oen_load(dm_oen_load),
    .dm_addr_load(dm_addr_load), .dm_datain_load(dm_datain_load),
    .pc(pc), .ir(ir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ri(input logic [6:0] op, input int d, input int a, input int imm);
    return {op, 5'(d), 5'(a), 15'(imm)};
  endfunction

  function automatic logic [31:0] rr(input logic [6:0] op, input int d, input int a, input int b);
    return {op, 5'(d), 5'(a), 5'(b), 10'b0};
  endfunction

  task automatic load_im(input int a, input logic [31:0] d);
    loading = 1; im_cen_load = 0; im_wen_load = 0; im_oen_load = 0;
    im_addr_load = 11'(a); im_datain_load = d;
    @(posedge clk); @(negedge clk);
    im_cen_load = 1; im_wen_load = 1; im_oen_load = 1;
  endtask

  task automatic load_dm(input int a, input logic [31:0] d);
    loading = 1; dm_cen_load = 0; dm_wen_load = 0;
    dm_addr_load = 11'(a); dm_datain_load = d;
    @(posedge clk); @(negedge clk);
    dm_cen_load = 1; dm_wen_load = 1;
  endtask

  task automatic start();
    rst_n = 0; #1; rst_n = 1; loading = 0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    load_im(0, ri(OP_ADI, 1, 0, 5));
    load_im(1, ri(OP_ADI, 2, 1, -7));
    start();
    check("reset_pc", pc, 32'd0);
    check("reset_ir", ir, ri(OP_ADI, 1, 0, 5));
    check("reset_r1", dut.rf[1], 32'd0);
    run(2);
    check("adi_r1", dut.rf[1], 32'd5);
    check("adi_neg_r2", dut.rf[2], 32'hFFFFFFFE);
    check("adi_pc", pc, 32'd2);

    load_dm(3, 32'd42);
    load_im(0, ri(OP_ADI, 1, 0, 3));
    load_im(1, ri(OP_LD, 2, 1, 0));
    load_im(2, rr(OP_ST, 0, 1, 1));
    start();
    run(2);
    check("ld_r2", dut.rf[2], 32'd42);
    check("ld_dm_pre", dut.dm[3], 32'd42);
    run(1);
    check("st_dm3", dut.dm[3], 32'd3);

    load_im(0, ri(OP_JMP, 0, 0, 10));
    load_im(10, ri(OP_BZ, 0, 1, -1));
    start();
    run(2);
    check("bz_taken", pc, 32'd9);

    load_im(0, ri(OP_ADI, 1, 0, 1));
    load_im(1, ri(OP_JMP, 0, 0, 9));
    load_im(10, ri(OP_BNZ, 0, 1, 4));
    load_im(14, ri(OP_BZ, 0, 1, 5));
    start();
    run(3);
    check("bnz_taken", pc, 32'd14);
    run(1);
    check("bz_not_taken", pc, 32'd15);

    load_im(0, ri(OP_JMP, 0, 0, 5));
    load_im(5, ri(OP_JML, 31, 0, 3));
    load_im(8, ri(OP_JMR, 0, 31, 0));
    start();
    run(2);
    check("jml_r31", dut.rf[31], 32'd6);
    check("jml_pc", pc, 32'd8);
    run(1);
    check("jmr_pc", pc, 32'd6);

    load_im(0, ri(OP_JMP, 0, 0, -1));
    load_im(2047, ri(OP_ADI, 7, 0, 7));
    start();
    run(1);
    check("wrap_pc", pc, 32'hFFFFFFFF);
    check("wrap_ir", ir, ri(OP_ADI, 7, 0, 7));
    run(1);
    check("wrap_r7", dut.rf[7], 32'd7);
    check("wrap_pc_next", pc, 32'd0);

    load_im(0,  ri(OP_ADI, 1, 0, 1));
    load_im(1,  ri(OP_LSL, 1, 1, 31));
    load_im(2,  ri(OP_ADI, 2, 0, 1));
    load_im(3,  rr(OP_SLT, 3, 1, 2));
    load_im(4,  ri(OP_LSR, 4, 1, 31));
    load_im(5,  ri(OP_LSL, 5, 2, 4));
    load_im(6,  ri(OP_ADI, 6, 0, 9));
    load_im(7,  rr(OP_SLT, 6, 2, 1));
    load_im(8,  rr(OP_SUB, 7, 2, 5));
    load_im(9,  rr(OP_XOR, 8, 7, 5));
    load_im(10, rr(OP_NOT, 9, 5, 0));
    load_im(11, rr(OP_AND, 10, 7, 8));
    load_im(12, rr(OP_OR, 11, 1, 5));
    load_im(13, ri(OP_ORI, 12, 0, 16'h4000));
    load_im(14, ri(OP_SBI, 13, 0, 1));
    load_im(15, ri(OP_ANI, 14, 13, 16'h7FFF));
    load_im(16, rr(OP_MOVB, 15, 0, 5));
    load_im(17, rr(OP_MOVA, 16, 11, 0));
    load_im(18, rr(OP_ADD, 17, 16, 16));
    load_im(19, ri(OP_XRI, 18, 13, 16'h00FF));
    load_im(20, ri(7'h7F, 19, 13, 5));
    start();
    run(21);
    check("lsl_r1", dut.rf[1], 32'h80000000);
    check("slt_r3", dut.rf[3], 32'd1);
    check("lsr_r4", dut.rf[4], 32'd1);
    check("lsl_r5", dut.rf[5], 32'd16);
    check("slt_r6", dut.rf[6], 32'd0);
    check("sub_r7", dut.rf[7], 32'hFFFFFFF1);
    check("xor_r8", dut.rf[8], 32'hFFFFFFE1);
    check("not_r9", dut.rf[9], 32'hFFFFFFEF);
    check("and_r10", dut.rf[10], 32'hFFFFFFE1);
    check("or_r11", dut.rf[11], 32'h80000010);
    check("ori_r12", dut.rf[12], 32'h00004000);
    check("sbi_r13", dut.rf[13], 32'hFFFFFFFF);
    check("ani_r14", dut.rf[14], 32'h00007FFF);
    check("movb_r15", dut.rf[15], 32'd16);
    check("mova_r16", dut.rf[16], 32'h80000010);
    check("add_r17", dut.rf[17], 32'h00000020);
    check("xri_r18", dut.rf[18], 32'hFFFFFF00);
    check("bad_op_r19", dut.rf[19], 32'd0);
    check("alu_pc", pc, 32'd21);

    load_im(0, ri(OP_ADI, 1, 1, 1));
    load_im(1, ri(OP_JMP, 0, 0, -1));
    start();
    run(5);
    check("loop_pc", pc, 32'd1);
    check("loop_r1", dut.rf[1], 32'd3);
    dm_cen_load = 0; dm_wen_load = 0; dm_addr_load = 11'd3; dm_datain_load = 32'd99;
    run(1);
    dm_cen_load = 1; dm_wen_load = 1;
    check("loop_pc6", pc, 32'd0);
    #2 rst_n = 0;
    #1;
    check("async_rst_pc", pc, 32'd0);
    check("async_rst_r1", dut.rf[1], 32'd0);
    check("rst_keeps_dm", dut.dm[3], 32'd3);
    @(negedge clk);
    rst_n = 1;
    run(1);
    check("resume_pc", pc, 32'd1);
    loading = 1;
    run(3);
    check("frozen_pc", pc, 32'd1);
    check("frozen_r1", dut.rf[1], 32'd1);
    loading = 0;
    run(1);
    check("unfrozen_pc", pc, 32'd0);
    run(1);
    check("unfrozen_r1", dut.rf[1], 32'd2);

    load_im(0, ri(OP_ADI, 0, 0, 9));
    load_im(1, rr(OP_MOVA, 1, 0, 0));
    start();
    run(2);
`ifdef PROCESSOR_R0_ZERO_EN
    check("r0_mova", dut.rf[1], 32'd0);
`else
    check("r0_mova", dut.rf[1], 32'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/processor_core.md
PROCESSOR_CORE -- requirements
Module: processor

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: loading  in  1  high = memory-load mode, core frozen.
REQ-004 SHALL have: im_cen_load, im_wen_load, im_oen_load  in  1 each  active-low chip enable, write enable and output enable for IM loading.
REQ-005 SHALL have: im_addr_load  in  11  IM word address; im_datain_load  in  32  IM write data.
REQ-006 SHALL have: dm_cen_load, dm_wen_load, dm_oen_load  in  1 each; dm_addr_load  in  11; dm_datain_load  in  32; same meaning for DM.
REQ-007 SHALL have: pc  out  32  address of the executing instruction; ir  out  32  the executing instruction word (debug only; may be left unconnected).

Function
REQ-008 SHALL contain a 2048x32 instruction memory (IM), a 2048x32 data memory (DM) and a 32x32 register file; IM and DM are word-addressed, reads combinational, writes on clk rising edge.
REQ-009 While loading=1, a memory SHALL be written at addr_load with datain_load on each rising edge where cen=0 and wen=0; oen is ignored; the core SHALL NOT update PC, registers or DM.
REQ-010 While loading=0, the load ports SHALL be ignored.
REQ-011 Single-cycle execution: each rising edge with rst_n=1 and loading=0 SHALL retire IM[pc[10:0]] and update pc; ir = IM[pc[10:0]] combinationally.
REQ-012 Fields: opcode=ir[31:25], dr=ir[24:20], sa=ir[19:15], sb=ir[14:10], imm=ir[14:0], sh=ir[4:0]; se(imm) = imm sign-extended to 32 bits, ze(imm) = zero-extended.
REQ-013 Non-control instructions SHALL set pc <= pc+1; all arithmetic is 32-bit modulo 2^32.
REQ-014 Encodings: NOP 0000000 no effect; MOVA 1000000 R[dr]=R[sa]; MOVB 0001100 R[dr]=R[sb]; ADD 0000010 R[dr]=R[sa]+R[sb]; SUB 0000101 R[dr]=R[sa]-R[sb].
REQ-015 AND 0001000, OR 0001001, XOR 0001010: bitwise R[sa] op R[sb] into R[dr]; NOT 0001011 R[dr]=~R[sa].
REQ-016 ADI/AIU 0100010 R[dr]=R[sa]+se(imm); SBI/SIU 0100101 R[dr]=R[sa]-se(imm); ANI 0101000, ORI 0101001, XRI 0101010 use ze(imm).
REQ-017 LSR 0001101 R[dr]=R[sa]>>sh (logical); LSL 0001110 R[dr]=R[sa]<<sh; sh=0 is a move.
REQ-018 SLT 1100101 R[dr]=1 if R[sa]<R[sb] (signed) else 0.
REQ-019 LD 0010000 R[dr]=DM[R[sa][10:0]]; ST 0100000 DM[R[sa][10:0]]=R[sb]; upper address bits ignored (wrap).
REQ-020 BZ 1100000: pc=pc+se(imm) if R[sa]==0 else pc+1; BNZ 1001000: pc=pc+se(imm) if R[sa]!=0 else pc+1.
REQ-021 JMP 1101000 pc=pc+se(imm); JML 0110000 R[dr]=pc+1 and pc=pc+se(imm); JMR 1110000 pc=R[sa].
REQ-022 Any other opcode SHALL execute as NOP.
REQ-023 IM fetch SHALL use pc[10:0]; pc beyond 2047 wraps.
REQ-024 When an instruction reads a register written by the same instruction, the pre-edge value SHALL be used.

Reset
REQ-025 rst_n=0 SHALL immediately clear pc to 0 and all registers to 0, independent of clk.
REQ-026 Reset SHALL NOT alter IM or DM contents; loading before the first reset SHALL be supported, the core being held by loading=1.
REQ-027 The first rising edge after rst_n rises (loading=0) SHALL execute IM[0].

Configuration
REQ-028 With macro PROCESSOR_R0_ZERO_EN defined, R0 SHALL read as 0 and writes to it SHALL be discarded; without it, R0 SHALL be an ordinary register.

Verification
REQ-029 Load IM[0]=ADI R1,R0,#5, IM[1]=ADI R2,R1,#-7, reset -> after 2 cycles R1=5, R2=0xFFFFFFFE, pc=2.
REQ-030 DM[3]=42; program ADI R1,R0,#3; LD R2,M[R1]; ST M[R1],R1 -> R2=42, then DM[3]=3.
REQ-031 R1=0: BZ R1,#-1 at pc=10 -> pc=9; R1=1: BNZ R1,#4 at pc=10 -> pc=14; JML R31,#3 at pc=5 -> R31=6, pc=8; JMR R31 -> pc=6.
REQ-032 R1=0x80000000, R2=1: SLT R3,R1,R2 -> R3=1; LSR R4,R1>>31 -> R4=1; LSL R5,R2<<4 -> R5=16.
REQ-033 Assert rst_n=0 mid-program between edges -> pc and registers 0 at once, DM unchanged; pulse loading=1 mid-run -> pc frozen for those cycles.
REQ-034 With PROCESSOR_R0_ZERO_EN: ADI R0,R0,#9 then MOVA R1,R0 -> R1=0; without: R1=9.
